// File: rtl/riscv_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: default bus widths,
// stall-vector bit indices per stage, and the per-edge action classifier.
package riscv_stage_reg_pkg;

    // Default bus widths used across the core.
    localparam int REG_ADDR_W_DEF = 5;
    localparam int REG_DATA_W_DEF = 32;
    localparam int MEM_ADDR_W_DEF = 32;
    localparam int STALL_W_DEF    = 6;

    // Stall vector bit owned by each pipeline stage.
    localparam int STALL_IF  = 0;
    localparam int STALL_ID  = 1;
    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;
    localparam int STALL_CTL = 5;

    // What the register does on a given clock edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

    // Flush beats everything; an unstalled stage loads; a stalled stage
    // holds only while the downstream stage is also stalled, else it
    // emits a bubble.
    function automatic stage_act_e classify(input logic flush,
                                            input logic st_own,
                                            input logic st_ds);
        if (flush)
            return ACT_FLUSH;
        if (!st_own)
            return ACT_LOAD;
        if (st_ds)
            return ACT_HOLD;
        return ACT_BUBBLE;
    endfunction

endpackage

// File: rtl/riscv_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module riscv_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt_o
);

    // Count up on inc, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_o <= '0;
        else if (inc && (cnt_o != {W{1'b1}}))
            cnt_o <= cnt_o + 1'b1;
    end

endmodule

// File: rtl/riscv_stage_reg.sv
// Parametrised pipeline stage register with valid bit, flush, load-response
// capture while held, sticky dropped-response flag and optional perf
// counters (enabled with `define RISCV_STAGE_PERF_EN).
module riscv_stage_reg
    import riscv_stage_reg_pkg::*;
#(
    parameter int STALL_W    = STALL_W_DEF,
    parameter int STAGE      = 3,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DATA_W     = REG_DATA_W_DEF,
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] rd_idx_i,
    input  logic                  rd_we_i,
    input  logic [DATA_W-1:0]     rd_wdata_i,
    input  logic [MEM_ADDR_W-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic                  data_re_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] rd_idx_o,
    output logic                  rd_we_o,
    output logic [DATA_W-1:0]     rd_wdata_o,
    output logic [MEM_ADDR_W-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic                  data_re_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  rdata_valid_o,
    output logic                  rsp_drop_o,
    output logic [31:0]           bubble_cnt_o,
    output logic [31:0]           hold_cnt_o,
    output logic [31:0]           flush_cnt_o
);

    logic       ds;
    stage_act_e act;
    logic       ld_pending;
    logic       capture;
    logic       drop;

    // The last stage has nothing downstream to stall it.
    if (STAGE < STALL_W - 1) begin : g_ds
        assign ds = stall[STAGE+1];
    end else begin : g_ds_last
        assign ds = 1'b0;
    end

    // Classify the edge and decide what a load response does this cycle.
    always_comb begin
        act        = classify(flush, stall[STAGE], ds);
        ld_pending = valid_o & data_re_o & ~rdata_valid_o;
        capture    = 1'b0;
        drop       = 1'b0;
        if (mem_rvalid_i && ld_pending) begin
            // Only a held register keeps its instruction; any other
            // action replaces it and the response has nowhere to go.
            if (act == ACT_HOLD)
                capture = 1'b1;
            else
                drop = 1'b1;
        end
    end

    // Instruction payload: zero on flush/bubble, load when unstalled, keep on hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o     <= 1'b0;
            rd_idx_o    <= '0;
            rd_we_o     <= 1'b0;
            rd_wdata_o  <= '0;
            data_addr_o <= '0;
            data_we_o   <= 1'b0;
            data_re_o   <= 1'b0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    valid_o     <= valid_i;
                    rd_idx_o    <= rd_idx_i;
                    rd_we_o     <= rd_we_i & valid_i;
                    rd_wdata_o  <= rd_wdata_i;
                    data_addr_o <= data_addr_i;
                    data_we_o   <= data_we_i & valid_i;
                    data_re_o   <= data_re_i & valid_i;
                end
                ACT_HOLD: ;
                default: begin
                    valid_o     <= 1'b0;
                    rd_idx_o    <= '0;
                    rd_we_o     <= 1'b0;
                    rd_wdata_o  <= '0;
                    data_addr_o <= '0;
                    data_we_o   <= 1'b0;
                    data_re_o   <= 1'b0;
                end
            endcase
        end
    end

    // Load data: captured once while held, cleared whenever the instruction changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
        end else if (act != ACT_HOLD) begin
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
        end else if (capture) begin
            rdata_o       <= mem_rdata_i;
            rdata_valid_o <= 1'b1;
        end
    end

    // Sticky record of a response that arrived for an instruction being replaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rsp_drop_o <= 1'b0;
        else if (drop)
            rsp_drop_o <= 1'b1;
    end

`ifdef RISCV_STAGE_PERF_EN
    riscv_sat_counter #(.W(32)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_BUBBLE),
        .cnt_o (bubble_cnt_o)
    );

    riscv_sat_counter #(.W(32)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_HOLD),
        .cnt_o (hold_cnt_o)
    );

    riscv_sat_counter #(.W(32)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (act == ACT_FLUSH),
        .cnt_o (flush_cnt_o)
    );
`else
    assign bubble_cnt_o = 32'd0;
    assign hold_cnt_o   = 32'd0;
    assign flush_cnt_o  = 32'd0;
`endif

endmodule
